useq_cs_address_sequencer: RTL and testbench

Microsequencer that produces the control-store address for the 41-bit microinstruction datapath. It holds the control-store address register (CSAR), evaluates the COND/JUMP_ADDR fields and the ALU flags to choose the next address, and stalls while a memory access is pending. It sits directly upstream of the microinstruction register: CSAR drives the combinational control-store ROM, whose output the MIR captures on the falling edge. The MIR's COND, JUMP_ADDR, RD and WR fields feed back into this block.

---
 rtl/useq_cs_address_sequencer_if.sv | 32 +++
 rtl/useq_cs_address_sequencer.sv | 79 +++++++
 tb/tb_useq_cs_address_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/useq_cs_address_sequencer_if.sv
// rtl/useq_cs_address_sequencer_if.sv - MIR/datapath-facing signal bundle of the microsequencer
interface useq_cs_address_sequencer_if #(
  parameter int JUMP_ADDR_BUS_WIDTH = 11,
  parameter int COND_BUS_WIDTH      = 3
);
  logic [COND_BUS_WIDTH-1:0]      USEQ_COND_IN;
  logic [JUMP_ADDR_BUS_WIDTH-1:0] USEQ_JUMP_ADDR_IN;
  logic                           USEQ_RD_IN;
  logic                           USEQ_WR_IN;
  logic                           USEQ_MemReady_In;
  logic [3:0]                     USEQ_ALUFlags_In;
  logic                           USEQ_FlagWrite_In;
  logic [31:0]                    USEQ_IR_In;
  logic [JUMP_ADDR_BUS_WIDTH-1:0] USEQ_CSAddr_OUT;
  logic [3:0]                     USEQ_Flags_OUT;
  logic                           USEQ_Stall_OUT;
  logic                           USEQ_Taken_OUT;

  // Surrounding datapath / MIR side
  modport master (
    output USEQ_COND_IN, USEQ_JUMP_ADDR_IN, USEQ_RD_IN, USEQ_WR_IN,
    output USEQ_MemReady_In, USEQ_ALUFlags_In, USEQ_FlagWrite_In, USEQ_IR_In,
    input  USEQ_CSAddr_OUT, USEQ_Flags_OUT, USEQ_Stall_OUT, USEQ_Taken_OUT
  );

  // Sequencer side
  modport slave (
    input  USEQ_COND_IN, USEQ_JUMP_ADDR_IN, USEQ_RD_IN, USEQ_WR_IN,
    input  USEQ_MemReady_In, USEQ_ALUFlags_In, USEQ_FlagWrite_In, USEQ_IR_In,
    output USEQ_CSAddr_OUT, USEQ_Flags_OUT, USEQ_Stall_OUT, USEQ_Taken_OUT
  );
endinterface

// File: rtl/useq_cs_address_sequencer.sv
// rtl/useq_cs_address_sequencer.sv - control-store address sequencer with flag register and memory stall
module useq_cs_address_sequencer #(
  parameter int JUMP_ADDR_BUS_WIDTH = 11,
  parameter int COND_BUS_WIDTH      = 3,
  parameter int RESET_ADDR          = 0
) (
  input logic USEQ_CLOCK_50,
  input logic USEQ_Reset_InLow,
  useq_cs_address_sequencer_if.slave bus
);
  localparam int W = JUMP_ADDR_BUS_WIDTH;

  // Flag bit positions within {N,Z,V,C}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  logic [W-1:0] csar;
  logic [3:0]   flags;
  logic         taken;

  logic         stall;
  logic [W-1:0] inc_addr;
  logic [10:0]  decode11;
  logic [W-1:0] decode_addr;
  logic [W-1:0] next_addr;
  logic         next_taken;

  // IR bits that never feed the decode or the COND=5 test
  logic unused_ir;
  assign unused_ir = ^{bus.USEQ_IR_In[29:25], bus.USEQ_IR_In[18:14], bus.USEQ_IR_In[12:0]};

  // The decode target is defined as an 11-bit pattern; fit it to the address width
  assign decode11    = {1'b1, bus.USEQ_IR_In[31:30], bus.USEQ_IR_In[24:19], 2'b00};
  assign decode_addr = W'(decode11);
  assign inc_addr    = csar + W'(1);

  // Stall whenever an access is requested and memory has not completed it
  always_comb begin
    stall = (bus.USEQ_RD_IN | bus.USEQ_WR_IN) & ~bus.USEQ_MemReady_In;
  end

  // Next-address select; branch tests look at the latched flags only
  always_comb begin
    next_addr  = inc_addr;
    next_taken = 1'b0;
    case (bus.USEQ_COND_IN)
      3'd1: if (flags[FLAG_N]) begin next_addr = bus.USEQ_JUMP_ADDR_IN; next_taken = 1'b1; end
      3'd2: if (flags[FLAG_Z]) begin next_addr = bus.USEQ_JUMP_ADDR_IN; next_taken = 1'b1; end
      3'd3: if (flags[FLAG_V]) begin next_addr = bus.USEQ_JUMP_ADDR_IN; next_taken = 1'b1; end
      3'd4: if (flags[FLAG_C]) begin next_addr = bus.USEQ_JUMP_ADDR_IN; next_taken = 1'b1; end
      3'd5: if (bus.USEQ_IR_In[13]) begin next_addr = bus.USEQ_JUMP_ADDR_IN; next_taken = 1'b1; end
      3'd6: begin next_addr = decode_addr; next_taken = 1'b1; end
      3'd7: begin next_addr = bus.USEQ_JUMP_ADDR_IN; next_taken = 1'b1; end
      default: begin next_addr = inc_addr; next_taken = 1'b0; end
    endcase
  end

  // CSAR, taken marker and flag register; everything holds while stalled
  always_ff @(posedge USEQ_CLOCK_50 or negedge USEQ_Reset_InLow) begin
    if (!USEQ_Reset_InLow) begin
      csar  <= W'(RESET_ADDR);
      flags <= 4'b0000;
      taken <= 1'b0;
    end else if (!stall) begin
      csar  <= next_addr;
      taken <= next_taken;
      if (bus.USEQ_FlagWrite_In) begin
        flags <= bus.USEQ_ALUFlags_In;
      end
    end
  end

  assign bus.USEQ_CSAddr_OUT = csar;
  assign bus.USEQ_Flags_OUT  = flags;
  assign bus.USEQ_Stall_OUT  = stall;
  assign bus.USEQ_Taken_OUT  = taken;
endmodule

// File: tb/tb_useq_cs_address_sequencer.sv
// tb/tb_useq_cs_address_sequencer.sv - directed vector bench for the control-store address sequencer
module tb_useq_cs_address_sequencer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  useq_cs_address_sequencer_if #(.JUMP_ADDR_BUS_WIDTH(11), .COND_BUS_WIDTH(3)) bus ();

  useq_cs_address_sequencer #(
    .JUMP_ADDR_BUS_WIDTH(11),
    .COND_BUS_WIDTH(3),
    .RESET_ADDR(0)
  ) dut (
    .USEQ_CLOCK_50(clk),
    .USEQ_Reset_InLow(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        rd;
    logic        wr;
    logic        mrdy;
    logic [3:0]  alu;
    logic        fw;
    logic [31:0] ir;
    logic        e_stall;
    logic [10:0] e_addr;
    logic [3:0]  e_flags;
    logic        e_taken;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] cond, input logic [10:0] jump, input logic rd,
                       input logic wr, input logic mrdy, input logic [3:0] alu,
                       input logic fw, input logic [31:0] ir);
    bus.USEQ_COND_IN      = cond;
    bus.USEQ_JUMP_ADDR_IN = jump;
    bus.USEQ_RD_IN        = rd;
    bus.USEQ_WR_IN        = wr;
    bus.USEQ_MemReady_In  = mrdy;
    bus.USEQ_ALUFlags_In  = alu;
    bus.USEQ_FlagWrite_In = fw;
    bus.USEQ_IR_In        = ir;
  endtask

  task automatic check_state(input string tag, input logic [10:0] a, input logic [3:0] f, input logic t);
    check({tag, ".csar"},  32'(bus.USEQ_CSAddr_OUT), 32'(a));
    check({tag, ".flags"}, 32'(bus.USEQ_Flags_OUT),  32'(f));
    check({tag, ".taken"}, 32'(bus.USEQ_Taken_OUT),  32'(t));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //                cond  jump     rd wr mr  alu    fw  ir            stall addr     flags  taken
    vecs[0]  = '{3'd0, 11'h000, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h002, 4'h0, 0};
    vecs[1]  = '{3'd7, 11'h7FF, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h7FF, 4'h0, 1};
    vecs[2]  = '{3'd0, 11'h000, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h000, 4'h0, 0};
    vecs[3]  = '{3'd0, 11'h000, 0, 0, 1, 4'h4, 1, 32'h0000_0000, 0, 11'h001, 4'h4, 0};
    vecs[4]  = '{3'd2, 11'h2A0, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h2A0, 4'h4, 1};
    vecs[5]  = '{3'd1, 11'h100, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h2A1, 4'h4, 0};
    vecs[6]  = '{3'd6, 11'h000, 0, 0, 1, 4'h0, 0, 32'h8A00_6001, 0, 11'h600, 4'h4, 1};
    vecs[7]  = '{3'd6, 11'h000, 0, 0, 1, 4'h0, 0, 32'h8A80_6001, 0, 11'h640, 4'h4, 1};
    vecs[8]  = '{3'd5, 11'h0AB, 0, 0, 1, 4'h0, 0, 32'h0000_2000, 0, 11'h0AB, 4'h4, 1};
    vecs[9]  = '{3'd5, 11'h300, 0, 0, 1, 4'h0, 0, 32'hFFFF_DFFF, 0, 11'h0AC, 4'h4, 0};
    vecs[10] = '{3'd3, 11'h111, 0, 0, 1, 4'hA, 1, 32'h0000_0000, 0, 11'h0AD, 4'hA, 0};
    vecs[11] = '{3'd3, 11'h111, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h111, 4'hA, 1};
    vecs[12] = '{3'd1, 11'h222, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h222, 4'hA, 1};
    vecs[13] = '{3'd4, 11'h333, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h223, 4'hA, 0};
    vecs[14] = '{3'd2, 11'h444, 0, 0, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h224, 4'hA, 0};
    vecs[15] = '{3'd7, 11'h055, 1, 1, 1, 4'h0, 0, 32'h0000_0000, 0, 11'h055, 4'hA, 1};
    vecs[16] = '{3'd0, 11'h000, 1, 0, 0, 4'h0, 0, 32'h0000_0000, 1, 11'h055, 4'hA, 1};
    vecs[17] = '{3'd4, 11'h3FF, 1, 0, 1, 4'h1, 1, 32'h0000_0000, 0, 11'h056, 4'h1, 0};

    // Reset, then jump somewhere non-zero with flags set
    rst_n = 1'b0;
    drive(3'd0, 11'h000, 0, 0, 1, 4'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(3'd7, 11'h123, 0, 0, 1, 4'hF, 1, 32'h0);
    @(posedge clk);
    #1;
    check_state("pre_reset", 11'h123, 4'hF, 1'b1);

    // Asynchronous reset between edges, with a stalling request present
    #3;
    drive(3'd0, 11'h000, 1, 0, 0, 4'h0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_state("async_reset", 11'h000, 4'h0, 1'b0);
    check("async_reset.stall", 32'(bus.USEQ_Stall_OUT), 32'd1);
    drive(3'd0, 11'h000, 0, 0, 1, 4'h0, 0, 32'h0);
    #1;
    check("reset_nostall", 32'(bus.USEQ_Stall_OUT), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("first_inc", 11'h001, 4'h0, 1'b0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].cond, vecs[i].jump, vecs[i].rd, vecs[i].wr, vecs[i].mrdy,
            vecs[i].alu, vecs[i].fw, vecs[i].ir);
      #1;
      check($sformatf("vec%0d.stall", i), 32'(bus.USEQ_Stall_OUT), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_flags, vecs[i].e_taken);
    end

    // Three-cycle read stall with FlagWrite held; release commits jump and flags
    drive(3'd7, 11'h050, 1, 0, 0, 4'hF, 1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d.stall", k), 32'(bus.USEQ_Stall_OUT), 32'd1);
      @(posedge clk);
      #1;
      check_state($sformatf("stall%0d", k), 11'h056, 4'h1, 1'b0);
    end
    drive(3'd7, 11'h050, 1, 0, 1, 4'h6, 1, 32'h0);
    #1;
    check("release.stall", 32'(bus.USEQ_Stall_OUT), 32'd0);
    @(posedge clk);
    #1;
    check_state("release", 11'h050, 4'h6, 1'b1);

    // Reset in the middle of a write stall
    drive(3'd7, 11'h310, 0, 0, 1, 4'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    check_state("to_310", 11'h310, 4'h6, 1'b1);
    drive(3'd0, 11'h000, 0, 1, 0, 4'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    check_state("wr_hold", 11'h310, 4'h6, 1'b1);
    check("wr_hold.stall", 32'(bus.USEQ_Stall_OUT), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("mid_stall_reset", 11'h000, 4'h0, 1'b0);
    #1;
    rst_n = 1'b1;
    drive(3'd0, 11'h000, 0, 0, 0, 4'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    check_state("after_reset", 11'h001, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
